// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/execute control FSM driving the ALU, register file and data memory.
module alu_sequencer #(
  parameter int PC_W  = 10,
  parameter int CYC_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [8:0]       Instr,
  input  logic [PC_W-1:0]  LutTarget,
  input  logic             Jen,
  input  logic             SCo,
  output logic [PC_W-1:0]  Prog_ctr,
  output logic [3:0]       Aluop,
  output logic [2:0]       Imm,
  output logic [1:0]       LutAddr,
  output logic [2:0]       RdAddrA,
  output logic [2:0]       RdAddrB,
  output logic [2:0]       WrAddr,
  output logic             RegWrEn,
  output logic             MemToReg,
  output logic             MemRdEn,
  output logic             MemWrEn,
  output logic             CarryFlag,
  output logic             Done,
  output logic [CYC_W-1:0] CycleCnt
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, DONE} state_t;
  state_t state_q, state_d;
  logic [8:0] ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [CYC_W-1:0] cyc_q, cyc_d, cyc_inc;
  logic carry_q, carry_d, done_q, done_d;
  logic [3:0] op;
  logic [2:0] f;
  logic [1:0] m;
  logic active, is_alu, is_carry;
  assign op = ir_q[8:5];
  assign f = ir_q[4:2];
  assign m = ir_q[1:0];
  assign active = state_q inside {FETCH, EXEC, MEM};
  assign is_alu = (op <= 4'd5) || (op[3:2] == 2'b10);
  assign is_carry = op inside {4'd1, 4'd2, 4'd10, 4'd11};
  assign pc_inc = pc_q + 1'b1;
  assign cyc_inc = &cyc_q ? cyc_q : cyc_q + 1'b1;
  // Decoded fields follow IR in every active state; MEM always writes back to R0.
  assign Aluop = active ? op : '0;
  assign Imm = active ? f : '0;
  assign RdAddrB = active ? f : '0;
  assign LutAddr = active ? m : '0;
  assign RdAddrA = '0;
  assign WrAddr = (active && state_q != MEM && m == 2'b01) ? f : '0;
  assign Prog_ctr = pc_q;
  assign CarryFlag = carry_q;
  assign Done = done_q;
  assign CycleCnt = cyc_q;
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    pc_d = pc_q;
    carry_d = carry_q;
    cyc_d = cyc_q;
    done_d = done_q;
    RegWrEn = 1'b0;
    MemToReg = 1'b0;
    MemRdEn = 1'b0;
    MemWrEn = 1'b0;
    case (state_q)
      IDLE, DONE: if (Start) begin
        state_d = FETCH;
        pc_d = '0;
        cyc_d = '0;
        carry_d = 1'b0;
        done_d = 1'b0;
      end
      FETCH: begin
        ir_d = Instr;
        cyc_d = cyc_inc;
        state_d = EXEC;
      end
      EXEC: begin
        cyc_d = cyc_inc;
        state_d = FETCH;
        pc_d = pc_inc;
        if (is_alu) begin
          RegWrEn = 1'b1;
          carry_d = is_carry ? SCo : carry_q;
        end else if (op[3:1] == 3'b011) pc_d = Jen ? LutTarget : pc_inc;
        else if (op == 4'b1100) begin
          MemRdEn = 1'b1;
          pc_d = pc_q;
          state_d = MEM;
        end else if (op == 4'b1101) MemWrEn = 1'b1;
        else if (op == 4'b1110) begin
          pc_d = pc_q;
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      MEM: begin
        MemRdEn = 1'b1;
        MemToReg = 1'b1;
        RegWrEn = 1'b1;
        cyc_d = cyc_inc;
        pc_d = pc_inc;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ir_q <= '0;
      pc_q <= '0;
      carry_q <= 1'b0;
      cyc_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      pc_q <= pc_d;
      carry_q <= carry_d;
      cyc_q <= cyc_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed-vector bench for alu_sequencer, plus a narrow instance for PC wrap and counter saturation.
module tb_alu_sequencer;
  logic clk = 1'b0, rst, start, start2, jen, sco;
  logic [8:0] rom [1024];
  logic [8:0] instr;
  logic [9:0] pc;
  logic [3:0] aluop;
  logic [2:0] imm, rda, rdb, wra;
  logic [1:0] lut_addr;
  logic reg_we, mem2reg, mem_re, mem_we, carry, done;
  logic [15:0] cyc;
  logic [1:0] pc2;
  logic [3:0] aluop2;
  logic [2:0] imm2, rda2, rdb2, wra2;
  logic [1:0] lut_addr2;
  logic reg_we2, mem2reg2, mem_re2, mem_we2, carry2, done2;
  logic [2:0] cyc2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign instr = rom[pc];
  alu_sequencer dut (
    .Clk(clk), .Reset(rst), .Start(start), .Instr(instr), .LutTarget(10'd40), .Jen(jen), .SCo(sco),
    .Prog_ctr(pc), .Aluop(aluop), .Imm(imm), .LutAddr(lut_addr), .RdAddrA(rda), .RdAddrB(rdb),
    .WrAddr(wra), .RegWrEn(reg_we), .MemToReg(mem2reg), .MemRdEn(mem_re), .MemWrEn(mem_we),
    .CarryFlag(carry), .Done(done), .CycleCnt(cyc)
  );
  alu_sequencer #(.PC_W(2), .CYC_W(3)) dut2 (
    .Clk(clk), .Reset(rst), .Start(start2), .Instr(9'b1111_000_00), .LutTarget(2'd0), .Jen(1'b0), .SCo(1'b0),
    .Prog_ctr(pc2), .Aluop(aluop2), .Imm(imm2), .LutAddr(lut_addr2), .RdAddrA(rda2), .RdAddrB(rdb2),
    .WrAddr(wra2), .RegWrEn(reg_we2), .MemToReg(mem2reg2), .MemRdEn(mem_re2), .MemWrEn(mem_we2),
    .CarryFlag(carry2), .Done(done2), .CycleCnt(cyc2)
  );
  task automatic load_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'b1111_000_00;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({pc, aluop, imm, lut_addr, rda, rdb, wra, reg_we, mem2reg, mem_re, mem_we, carry, cyc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pc=%0d aluop=%0d we=%b re=%b cyc=%0d exp all 0", pc, aluop, reg_we, mem_re, cyc);
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pc, aluop, reg_we, done, cyc} !== '0) begin
      errors++;
      $display("FAIL idle_hold got pc=%0d aluop=%0d done=%b cyc=%0d exp 0", pc, aluop, done, cyc);
    end
  endtask
  task automatic test_alu();
    load_rom();
    rom[0] = 9'b0001_011_01;
    rom[1] = 9'b0000_110_00;
    rom[2] = 9'b1110_000_00;
    do_reset();
    sco = 1'b1;
    kick();
    checks++;
    if (reg_we !== 1'b0) begin errors++; $display("FAIL alu_fetch_we got %b exp 0", reg_we); end
    @(negedge clk);
    checks++;
    if ({aluop, rdb, wra, imm, lut_addr, reg_we} !== {4'b0001, 3'd3, 3'd3, 3'd3, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL alu_exec got aluop=%b rdb=%0d wra=%0d imm=%0d lut=%0d we=%b exp 0001 3 3 3 1 1", aluop, rdb, wra, imm, lut_addr, reg_we);
    end
    checks++;
    if (carry !== 1'b0) begin errors++; $display("FAIL alu_carry_early got %b exp 0", carry); end
    @(negedge clk);
    sco = 1'b0;
    checks++;
    if ({carry, pc, reg_we} !== {1'b1, 10'd1, 1'b0}) begin
      errors++;
      $display("FAIL alu_after got carry=%b pc=%0d we=%b exp 1 1 0", carry, pc, reg_we);
    end
    @(negedge clk);
    checks++;
    if ({aluop, wra, reg_we} !== {4'b0000, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL alu_op0_exec got aluop=%b wra=%0d we=%b exp 0000 0 1", aluop, wra, reg_we);
    end
    @(negedge clk);
    checks++;
    if ({carry, pc} !== {1'b1, 10'd2}) begin
      errors++;
      $display("FAIL alu_carry_hold got carry=%b pc=%0d exp 1 2", carry, pc);
    end
  endtask
  task automatic test_branch();
    load_rom();
    rom[1] = 9'b0111_010_10;
    rom[2] = 9'b1110_000_00;
    rom[40] = 9'b1110_000_00;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      jen = (t == 0);
      kick();
      repeat (3) @(negedge clk);
      checks++;
      if ({aluop, lut_addr, reg_we, mem_re, mem_we} !== {4'b0111, 2'd2, 3'b000}) begin
        errors++;
        $display("FAIL branch_exec got aluop=%b lut=%0d we=%b exp 0111 2 0", aluop, lut_addr, reg_we);
      end
      @(negedge clk);
      checks++;
      if (pc !== (t == 0 ? 10'd40 : 10'd2)) begin
        errors++;
        $display("FAIL branch_pc jen=%b got %0d exp %0d", jen, pc, (t == 0 ? 40 : 2));
      end
    end
    jen = 1'b0;
  endtask
  task automatic test_load_store();
    load_rom();
    rom[0] = 9'b1100_101_01;
    rom[1] = 9'b1101_010_00;
    rom[2] = 9'b1110_000_00;
    do_reset();
    kick();
    checks++;
    if (mem_re !== 1'b0) begin errors++; $display("FAIL load_fetch_re got %b exp 0", mem_re); end
    @(negedge clk);
    checks++;
    if ({mem_re, mem2reg, reg_we, wra} !== {3'b100, 3'd5}) begin
      errors++;
      $display("FAIL load_exec got re=%b m2r=%b we=%b wra=%0d exp 1 0 0 5", mem_re, mem2reg, reg_we, wra);
    end
    @(negedge clk);
    checks++;
    if ({mem_re, mem2reg, reg_we, wra, pc} !== {3'b111, 3'd0, 10'd0}) begin
      errors++;
      $display("FAIL load_mem got re=%b m2r=%b we=%b wra=%0d pc=%0d exp 1 1 1 0 0", mem_re, mem2reg, reg_we, wra, pc);
    end
    @(negedge clk);
    checks++;
    if ({pc, mem_re, mem2reg, reg_we} !== {10'd1, 3'b000}) begin
      errors++;
      $display("FAIL load_after got pc=%0d re=%b m2r=%b we=%b exp 1 0 0 0", pc, mem_re, mem2reg, reg_we);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, rdb, reg_we, mem_re} !== {1'b1, 3'd2, 2'b00}) begin
      errors++;
      $display("FAIL store_exec got we_mem=%b rdb=%0d we=%b re=%b exp 1 2 0 0", mem_we, rdb, reg_we, mem_re);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, pc} !== {1'b0, 10'd2}) begin
      errors++;
      $display("FAIL store_after got we_mem=%b pc=%0d exp 0 2", mem_we, pc);
    end
  endtask
  task automatic test_halt_restart();
    load_rom();
    rom[2] = 9'b1110_000_00;
    do_reset();
    kick();
    repeat (6) @(negedge clk);
    checks++;
    if ({done, pc, cyc, aluop} !== {1'b1, 10'd2, 16'd6, 4'd0}) begin
      errors++;
      $display("FAIL halt got done=%b pc=%0d cyc=%0d aluop=%0d exp 1 2 6 0", done, pc, cyc, aluop);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({done, pc, cyc} !== {1'b1, 10'd2, 16'd6}) begin
      errors++;
      $display("FAIL halt_hold got done=%b pc=%0d cyc=%0d exp 1 2 6", done, pc, cyc);
    end
    kick();
    checks++;
    if ({done, pc, cyc} !== {1'b0, 10'd0, 16'd0}) begin
      errors++;
      $display("FAIL restart got done=%b pc=%0d cyc=%0d exp 0 0 0", done, pc, cyc);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    checks++;
    if ({pc, cyc} !== {10'd1, 16'd2}) begin
      errors++;
      $display("FAIL start_ignored got pc=%0d cyc=%0d exp 1 2", pc, cyc);
    end
  endtask
  task automatic test_reset_mid_mem();
    load_rom();
    rom[0] = 9'b1100_000_00;
    do_reset();
    kick();
    repeat (2) @(negedge clk);
    checks++;
    if (reg_we !== 1'b1) begin errors++; $display("FAIL mem_pre_reset got we=%b exp 1", reg_we); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({reg_we, mem_re, mem2reg, aluop} !== '0) begin
      errors++;
      $display("FAIL async_reset got we=%b re=%b m2r=%b aluop=%0d exp 0", reg_we, mem_re, mem2reg, aluop);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pc, cyc, aluop, reg_we} !== '0) begin
      errors++;
      $display("FAIL reset_idle got pc=%0d cyc=%0d aluop=%0d exp 0", pc, cyc, aluop);
    end
  endtask
  task automatic test_wrap();
    logic [1:0] exp_pc [5];
    exp_pc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pc2 !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc step %0d got %0d exp %0d", i, pc2, exp_pc[i]); end
      repeat (2) @(negedge clk);
    end
    checks++;
    if ({cyc2, done2} !== {3'd7, 1'b0}) begin
      errors++;
      $display("FAIL cyc_saturate got cyc=%0d done=%b exp 7 0", cyc2, done2);
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    jen = 1'b0;
    sco = 1'b0;
    load_rom();
    test_reset();
    test_alu();
    test_branch();
    test_load_store();
    test_halt_restart();
    test_reset_mid_mem();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
